// File: rtl/sdram_if_pkg.sv
// Shared bridge constants and writer state encoding for the SDRAM line writer.
package sdram_if_pkg;

    localparam int INTERFACE_WIDTH_BITS  = 128;
    localparam int INTERFACE_ADDR_BITS   = 26;
    localparam int INTERFACE_WIDTH_BYTES = INTERFACE_WIDTH_BITS / 8;
    localparam int LINE_BYTES            = INTERFACE_WIDTH_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } writer_state_t;

endpackage

// File: rtl/sdram_line_writer_if.sv
// Word stream, session control and bridge write-side signals of the SDRAM line writer.
interface sdram_line_writer_if #(
    parameter int INTERFACE_WIDTH_BITS = sdram_if_pkg::INTERFACE_WIDTH_BITS,
    parameter int INTERFACE_ADDR_BITS  = sdram_if_pkg::INTERFACE_ADDR_BITS,
    parameter int WORD_BITS            = 32
);

    logic                                start;
    logic [INTERFACE_ADDR_BITS-1:0]      base_address;
    logic                                word_valid;
    logic [WORD_BITS-1:0]                word_data;
    logic                                word_ready;
    logic                                flush;
    logic [INTERFACE_ADDR_BITS-1:0]      interface_address;
    logic [INTERFACE_WIDTH_BITS/8-1:0]   interface_byte_enable;
    logic                                interface_write;
    logic [INTERFACE_WIDTH_BITS-1:0]     interface_write_data;
    logic                                interface_acknowledge;
    logic                                busy;
    logic                                done;
    logic [15:0]                         lines_written;
    logic                                timeout_error;

    modport master (
        input  start, base_address, word_valid, word_data, flush, interface_acknowledge,
        output word_ready, interface_address, interface_byte_enable, interface_write,
               interface_write_data, busy, done, lines_written, timeout_error
    );

    modport slave (
        output start, base_address, word_valid, word_data, flush, interface_acknowledge,
        input  word_ready, interface_address, interface_byte_enable, interface_write,
               interface_write_data, busy, done, lines_written, timeout_error
    );

endinterface

// File: rtl/sdram_line_writer_line_packer.sv
// Packs narrow words into one bridge line, lane 0 first, and derives the matching byte enables.
module sdram_line_writer_line_packer #(
    parameter int WIDTH_BITS  = 128,
    parameter int WORD_BITS   = 32,
    localparam int LANES      = WIDTH_BITS / WORD_BITS,
    localparam int COUNT_BITS = $clog2(LANES + 1),
    localparam int LANE_BYTES = WORD_BITS / 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic                    i_flushClear,
    input  logic [WORD_BITS-1:0]    i_word,
    output logic                    o_full,
    output logic [COUNT_BITS-1:0]   o_count,
    output logic [WIDTH_BITS-1:0]   o_line,
    output logic [WIDTH_BITS/8-1:0] o_byteEnable
);

    logic [COUNT_BITS-1:0]   r_count;
    logic [WIDTH_BITS-1:0]   r_line;
    logic [WIDTH_BITS/8-1:0] w_byteEnable;

    // Clearing zeroes the data too, so unfilled lanes of a partial line go out as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_line  <= '0;
        end else if (i_flushClear) begin
            r_count <= '0;
            r_line  <= '0;
        end else if (i_push && !o_full) begin
            for (int k = 0; k < LANES; k++) begin
                if (r_count == COUNT_BITS'(k)) begin
                    r_line[k*WORD_BITS +: WORD_BITS] <= i_word;
                end
            end
            r_count <= r_count + COUNT_BITS'(1);
        end
    end

    always_comb begin
        w_byteEnable = '0;
        for (int k = 0; k < LANES; k++) begin
            if (COUNT_BITS'(k) < r_count) begin
                w_byteEnable[k*LANE_BYTES +: LANE_BYTES] = '1;
            end
        end
    end

    assign o_full       = (r_count == COUNT_BITS'(LANES));
    assign o_count      = r_count;
    assign o_line       = r_line;
    assign o_byteEnable = w_byteEnable;

endmodule

// File: rtl/sdram_line_writer.sv
// Packs result words into 128-bit lines and writes them to consecutive SDRAM lines over the bridge.
// Optional ack watchdog enabled by defining SDRAM_WRITER_TIMEOUT_EN.
module sdram_line_writer #(
    parameter int INTERFACE_WIDTH_BITS = sdram_if_pkg::INTERFACE_WIDTH_BITS,
    parameter int INTERFACE_ADDR_BITS  = sdram_if_pkg::INTERFACE_ADDR_BITS,
    parameter int WORD_BITS            = 32,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                clk,
    input  logic                reset,
    sdram_line_writer_if.master bus
);
    import sdram_if_pkg::*;

    localparam int LANES      = INTERFACE_WIDTH_BITS / WORD_BITS;
    localparam int COUNT_BITS = $clog2(LANES + 1);
    localparam int BE_BITS    = INTERFACE_WIDTH_BITS / 8;
    localparam logic [INTERFACE_ADDR_BITS-1:0] LINE_STEP  = INTERFACE_ADDR_BITS'(BE_BITS);
    localparam logic [INTERFACE_ADDR_BITS-1:0] ALIGN_MASK = INTERFACE_ADDR_BITS'(BE_BITS - 1);

    if ((INTERFACE_WIDTH_BITS % WORD_BITS) != 0) begin : g_badWordBits
        $error("WORD_BITS must divide INTERFACE_WIDTH_BITS");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    writer_state_t                  r_state;
    writer_state_t                  w_next;
    logic [INTERFACE_ADDR_BITS-1:0] r_addr;
    logic [15:0]                    r_lines;
    logic                           r_flushPend;
    logic                           w_accept;
    logic                           w_ack;
    logic                           w_clear;
    logic                           w_timeout;
    logic                           w_full;
    logic                           w_wordReady;
    logic                           w_write;
    logic                           w_busy;
    logic                           w_done;
    logic [COUNT_BITS-1:0]          w_count;
    logic [INTERFACE_WIDTH_BITS-1:0] w_line;
    logic [BE_BITS-1:0]             w_byteEnable;

    assign w_accept = (r_state == FILL) && !w_full && bus.word_valid;
    assign w_ack    = (r_state == WRITE) && bus.interface_acknowledge;
    assign w_clear  = w_ack || w_timeout;

    sdram_line_writer_line_packer #(
        .WIDTH_BITS (INTERFACE_WIDTH_BITS),
        .WORD_BITS  (WORD_BITS)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_accept),
        .i_flushClear (w_clear),
        .i_word       (bus.word_data),
        .o_full       (w_full),
        .o_count      (w_count),
        .o_line       (w_line),
        .o_byteEnable (w_byteEnable)
    );

`ifdef SDRAM_WRITER_TIMEOUT_EN
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_BITS-1:0] r_tmoCount;
    logic                r_timeoutError;

    assign w_timeout = (r_state == WRITE) && !bus.interface_acknowledge &&
                       (r_tmoCount == TMO_BITS'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent waiting in WRITE; the error flag stays set until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmoCount     <= '0;
            r_timeoutError <= 1'b0;
        end else begin
            if (r_state == WRITE && !w_clear) r_tmoCount <= r_tmoCount + TMO_BITS'(1);
            else                              r_tmoCount <= '0;
            if (w_timeout) r_timeoutError <= 1'b1;
        end
    end

    assign bus.timeout_error = r_timeoutError;
`else
    assign w_timeout         = 1'b0;
    assign bus.timeout_error = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        w_wordReady = 1'b0;
        w_write     = 1'b0;
        w_busy      = (r_state != IDLE);
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = FILL;
            end
            FILL: begin
                w_wordReady = !w_full;
                // A word arriving with flush joins the flushed line.
                if (bus.flush) begin
                    w_next = (w_count != '0 || w_accept) ? WRITE : DONE;
                end else if (w_accept && w_count == COUNT_BITS'(LANES - 1)) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                w_write = 1'b1;
                if (w_ack)          w_next = (r_flushPend || bus.flush) ? DONE : FILL;
                else if (w_timeout) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_lines     <= '0;
            r_flushPend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.start) begin
                r_addr      <= bus.base_address & ~ALIGN_MASK;
                r_lines     <= '0;
                r_flushPend <= 1'b0;
            end
            if ((r_state == FILL || r_state == WRITE) && bus.flush) r_flushPend <= 1'b1;
            if (w_ack) begin
                r_addr <= r_addr + LINE_STEP;
                if (r_lines != 16'hFFFF) r_lines <= r_lines + 16'd1;
            end
            if (r_state == DONE) r_flushPend <= 1'b0;
        end
    end

    assign bus.word_ready            = w_wordReady;
    assign bus.interface_write       = w_write;
    assign bus.interface_address     = r_addr;
    assign bus.interface_write_data  = w_line;
    assign bus.interface_byte_enable = w_byteEnable;
    assign bus.busy                  = w_busy;
    assign bus.done                  = w_done;
    assign bus.lines_written         = r_lines;

endmodule

// File: tb/tb_sdram_line_writer.sv
// Directed bench for sdram_line_writer: a bridge responder with programmable ack delay records lines.
// Timeout checks run only when SDRAM_WRITER_TIMEOUT_EN is defined.
module tb_sdram_line_writer;

    localparam int AW = 26;
    localparam int DW = 128;
    localparam int WB = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int ackDelay = 0;
    int lastAckCycle = 0;
    int waitCnt = 0;
    int doneCycle;
    int writeCycles;

    logic [AW-1:0] obsAddr[$];
    logic [DW-1:0] obsData[$];
    logic [15:0]   obsBe[$];
    logic [AW-1:0] holdAddr;
    logic [DW-1:0] holdData;
    logic [15:0]   holdBe;

    sdram_line_writer_if #(
        .INTERFACE_WIDTH_BITS (DW),
        .INTERFACE_ADDR_BITS  (AW),
        .WORD_BITS            (WB)
    ) bus ();

    sdram_line_writer #(
        .INTERFACE_WIDTH_BITS (DW),
        .INTERFACE_ADDR_BITS  (AW),
        .WORD_BITS            (WB),
        .TIMEOUT_CYCLES       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Bridge responder: acks after ackDelay waiting cycles and checks the request holds still meanwhile.
    always @(negedge clk) begin
        bus.interface_acknowledge = 1'b0;
        if (reset || !bus.interface_write) begin
            waitCnt = 0;
        end else begin
            if (waitCnt == 0) begin
                holdAddr = bus.interface_address;
                holdData = bus.interface_write_data;
                holdBe   = bus.interface_byte_enable;
            end else begin
                checkOutput("holdAddr", bus.interface_address, holdAddr);
                checkOutput("holdData", bus.interface_write_data, holdData);
                checkOutput("holdBe", bus.interface_byte_enable, holdBe);
                checkOutput("readyInWrite", bus.word_ready, 1'b0);
            end
            if (waitCnt >= ackDelay) begin
                bus.interface_acknowledge = 1'b1;
                obsAddr.push_back(bus.interface_address);
                obsData.push_back(bus.interface_write_data);
                obsBe.push_back(bus.interface_byte_enable);
                lastAckCycle = cycleCount;
                waitCnt = 0;
            end else begin
                waitCnt++;
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic [AW-1:0] base, input logic fl);
        bus.start        = st;
        bus.base_address = base;
        bus.flush        = fl;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic sendWords(input int n, input logic [31:0] first);
        logic [31:0] v;
        int guard;
        v = first;
        for (int i = 0; i < n; i++) begin
            bus.word_valid = 1'b1;
            bus.word_data  = v;
            guard = 0;
            while (!bus.word_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("wordReady", bus.word_ready, 1'b1);
            @(negedge clk);
            v = v + 32'd1;
        end
        bus.word_valid = 1'b0;
    endtask

    task automatic waitLines(input int n);
        int guard;
        guard = 0;
        while (bus.lines_written != 16'(n) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("linesReached", bus.lines_written, 16'(n));
    endtask

    task automatic waitDone();
        int guard;
        guard = 0;
        while (!bus.done && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("doneSeen", bus.done, 1'b1);
        doneCycle = cycleCount;
        @(negedge clk);
        checkOutput("donePulse", bus.done, 1'b0);
        checkOutput("idleAfterDone", bus.busy, 1'b0);
    endtask

    task automatic checkLine(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [15:0] be);
        if (idx < obsAddr.size()) begin
            checkOutput($sformatf("line%0dAddr", idx), obsAddr[idx], addr);
            checkOutput($sformatf("line%0dData", idx), obsData[idx], data);
            checkOutput($sformatf("line%0dBe", idx), obsBe[idx], be);
        end else begin
            checkOutput("lineMissing", obsAddr.size(), idx + 1);
        end
    endtask

    task automatic clearLines();
        obsAddr.delete();
        obsData.delete();
        obsBe.delete();
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.base_address = '0;
        bus.word_valid   = 1'b0;
        bus.word_data    = '0;
        bus.flush        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstWrite", bus.interface_write, 1'b0);
        checkOutput("rstBusy", bus.busy, 1'b0);
        checkOutput("rstDone", bus.done, 1'b0);
        checkOutput("rstLines", bus.lines_written, 16'h0);
        checkOutput("rstAddr", bus.interface_address, 26'h0);
        checkOutput("rstReady", bus.word_ready, 1'b0);
        checkOutput("rstBe", bus.interface_byte_enable, 16'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] two full lines, zero-wait ack");
        ackDelay = 0;
        clearLines();
        applyStimulus(1'b1, 26'h0000010, 1'b0);
        sendWords(8, 32'h1);
        waitLines(2);
        checkOutput("busyInSession", bus.busy, 1'b1);
        checkOutput("nLinesA", obsAddr.size(), 2);
        checkLine(0, 26'h10, {32'h4, 32'h3, 32'h2, 32'h1}, 16'hFFFF);
        checkLine(1, 26'h20, {32'h8, 32'h7, 32'h6, 32'h5}, 16'hFFFF);
        applyStimulus(1'b0, 26'h0, 1'b1);
        waitDone();
        checkOutput("linesAfterA", bus.lines_written, 16'd2);
        checkOutput("nLinesAEnd", obsAddr.size(), 2);

        $display("[TB] partial line via flush, unaligned base");
        clearLines();
        applyStimulus(1'b1, 26'h0000105, 1'b0);
        sendWords(6, 32'h11);
        applyStimulus(1'b0, 26'h0, 1'b1);
        waitDone();
        checkOutput("doneAfterAck", doneCycle, lastAckCycle + 1);
        checkOutput("nLinesB", obsAddr.size(), 2);
        checkLine(0, 26'h100, {32'h14, 32'h13, 32'h12, 32'h11}, 16'hFFFF);
        checkLine(1, 26'h110, {32'h0, 32'h0, 32'h16, 32'h15}, 16'h00FF);
        checkOutput("linesAfterB", bus.lines_written, 16'd2);

        $display("[TB] ack delayed 7 cycles with word_valid held");
        ackDelay = 7;
        clearLines();
        applyStimulus(1'b1, 26'h0000200, 1'b0);
        sendWords(8, 32'h21);
        waitLines(2);
        applyStimulus(1'b0, 26'h0, 1'b1);
        waitDone();
        checkOutput("nLinesC", obsAddr.size(), 2);
        checkLine(0, 26'h200, {32'h24, 32'h23, 32'h22, 32'h21}, 16'hFFFF);
        checkLine(1, 26'h210, {32'h28, 32'h27, 32'h26, 32'h25}, 16'hFFFF);
`ifndef SDRAM_WRITER_TIMEOUT_EN
        checkOutput("timeoutTied", bus.timeout_error, 1'b0);
`endif

        $display("[TB] word and flush together, start ignored while busy");
        ackDelay = 0;
        clearLines();
        applyStimulus(1'b1, 26'h0000300, 1'b0);
        applyStimulus(1'b1, 26'h0000900, 1'b0);
        sendWords(2, 32'h31);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h33;
        bus.flush      = 1'b1;
        @(negedge clk);
        bus.word_valid = 1'b0;
        bus.flush      = 1'b0;
        waitDone();
        checkOutput("nLinesD", obsAddr.size(), 1);
        checkLine(0, 26'h300, {32'h0, 32'h33, 32'h32, 32'h31}, 16'h0FFF);
        checkOutput("linesAfterD", bus.lines_written, 16'd1);
        applyStimulus(1'b0, 26'h0, 1'b1);
        checkOutput("flushIdleBusy", bus.busy, 1'b0);
        checkOutput("flushIdleDone", bus.done, 1'b0);

        $display("[TB] address wrap, then reset during second write");
        clearLines();
        applyStimulus(1'b1, 26'h3FFFFF0, 1'b0);
        sendWords(4, 32'h41);
        waitLines(1);
        ackDelay = 50;
        sendWords(4, 32'h45);
        checkOutput("wrapWrite", bus.interface_write, 1'b1);
        checkOutput("wrapAddr", bus.interface_address, 26'h0000000);
        checkOutput("wrapData", bus.interface_write_data, {32'h48, 32'h47, 32'h46, 32'h45});
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncWrite", bus.interface_write, 1'b0);
        checkOutput("asyncBusy", bus.busy, 1'b0);
        checkOutput("asyncLines", bus.lines_written, 16'h0);
        checkOutput("asyncBe", bus.interface_byte_enable, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        ackDelay = 0;
        checkOutput("nLinesE", obsAddr.size(), 1);
        checkLine(0, 26'h3FFFFF0, {32'h44, 32'h43, 32'h42, 32'h41}, 16'hFFFF);

`ifdef SDRAM_WRITER_TIMEOUT_EN
        $display("[TB] ack withheld until watchdog expires");
        ackDelay = 100000;
        clearLines();
        applyStimulus(1'b1, 26'h0000500, 1'b0);
        sendWords(4, 32'h51);
        writeCycles = 0;
        for (int g = 0; g < 100 && !bus.done; g++) begin
            if (bus.interface_write) writeCycles++;
            @(negedge clk);
        end
        checkOutput("tmoWriteCycles", writeCycles, 16);
        checkOutput("tmoError", bus.timeout_error, 1'b1);
        waitDone();
        checkOutput("tmoLines", bus.lines_written, 16'h0);
        checkOutput("tmoSticky", bus.timeout_error, 1'b1);
        checkOutput("nLinesF", obsAddr.size(), 0);
        ackDelay = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sdram_line_writer.md
Name: sdram_line_writer

Overview:
Write-side counterpart of sdram_reader on the External Bridge to Avalon Master interface. It accepts 32-bit result words (e.g. fp_mac results, mlp outputs), packs four of them into one 128-bit line, and issues bridge write transactions to consecutive 16-byte-aligned SDRAM addresses. It shares the bridge write-side signals with sdram_reader; the top level guarantees the two never drive transactions at the same time.

Parameters:
INTERFACE_WIDTH_BITS, 128, bridge data width.
INTERFACE_ADDR_BITS, 26, bridge byte-address width.
WORD_BITS, 32, input word width; must divide INTERFACE_WIDTH_BITS.
TIMEOUT_CYCLES, 1024, ack watchdog limit; used only with SDRAM_WRITER_TIMEOUT_EN.

Ports:
clk  in  1  single clock (clk_50 at top).
reset  in  1  asynchronous, active-high reset (reset_p at top).
start  in  1  one-cycle pulse; begins a session; honoured only in IDLE.
base_address  in  INTERFACE_ADDR_BITS  session start byte address; sampled on start.
word_valid  in  1  input word present.
word_data  in  WORD_BITS  input word.
word_ready  out  1  word accepted when word_valid && word_ready.
flush  in  1  one-cycle pulse; write any partial line, then end the session.
interface_address  out  INTERFACE_ADDR_BITS  bridge address.
interface_byte_enable  out  INTERFACE_WIDTH_BITS/8  bridge byte enables.
interface_write  out  1  bridge write request.
interface_write_data  out  INTERFACE_WIDTH_BITS  bridge write data.
interface_acknowledge  in  1  bridge ack.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse at session end.
lines_written  out  16  count of lines acknowledged in the current session.
timeout_error  out  1  sticky error flag (feature only; otherwise tied to 0).

Behaviour:
- Reset: state IDLE; all outputs 0; line register, lane count and address register cleared. Reset asserted mid-write drops interface_write immediately; that transaction is abandoned.
- LANES = INTERFACE_WIDTH_BITS/WORD_BITS (4). Lane k occupies bits [32k+31:32k]; the first word accepted goes to lane 0, matching the sdram_reader data_reg ordering.
- States:
  - IDLE: on start, latch base_address with bits [3:0] forced to 0, clear lines_written, go to FILL.
  - FILL: word_ready = 1 while lane count < LANES. On each accepted word, write the lane and increment the count. When the 4th word is accepted, go to WRITE on the next cycle.
  - FILL, flush: if lane count > 0, go to WRITE with the partial line and set flush_pend. If lane count = 0, go to DONE.
  - FILL, word and flush in the same cycle: the word is accepted first and is included in the flushed line.
  - WRITE: interface_write = 1. Address, data and byte_enable are registered and held stable until interface_acknowledge is sampled high. byte_enable = 4'hF for each filled lane and 0 for unfilled lanes; unfilled data lanes are 0. word_ready = 0.
  - WRITE, ack: on the same edge, deassert interface_write, add 16 to the address, increment lines_written and clear the lane count. Then go to DONE if flush_pend is set, otherwise to FILL.
  - WRITE, flush arriving: latched into flush_pend.
  - DONE: done = 1 for exactly one cycle; clear flush_pend; go to IDLE.
- start while not in IDLE is ignored. flush in IDLE is ignored.
- Address wraps modulo 2^INTERFACE_ADDR_BITS. lines_written saturates at 16'hFFFF.
- Throughput: at most one line per 5 cycles (4 fill + 1 write) with zero-wait ack. Latency from the 4th word accepted to interface_write high is 1 cycle.

Optional Feature:
SDRAM_WRITER_TIMEOUT_EN:
- Defined: a counter runs while in WRITE. If it reaches TIMEOUT_CYCLES without an ack, set timeout_error (sticky until reset), deassert interface_write, pulse done and go to IDLE.
- Undefined: no counter; WRITE waits indefinitely; timeout_error is tied to 0.

Decomposition:
- Package sdram_if_pkg holds:
  - INTERFACE_WIDTH_BITS / INTERFACE_ADDR_BITS defaults and the derived INTERFACE_WIDTH_BYTES / LINE_BYTES.
  - writer_state_t enum {IDLE, FILL, WRITE, DONE}.
- Natural sub-module: line_packer. It holds the lane register, lane count and byte-enable generation, with inputs push/flush_clear and outputs full/count/line/byte_enable. The top FSM handles the handshake and addressing.

Test Plan:
- start with base 0x0000010, then 8 words 0x1..0x8, zero-wait ack -> two writes:
  - addr 0x10, data {4,3,2,1}, be 16'hFFFF;
  - addr 0x20, data {8,7,6,5};
  - lines_written = 2.
- 6 words then flush -> second line written with data {0,0,6,5} and be 16'h00FF; done pulses 1 cycle after its ack.
- Ack delayed 7 cycles while word_valid is held high -> word_ready = 0, write signals stable for all 7 cycles, and no word is lost (scoreboard).
- Word and flush in the same cycle with lane count 2 -> be 16'h0FFF and 3 words written.
- Base 0x3FFFFF0 with 8 words -> second line at address 0x0000000 (wraps); reset asserted during the 2nd WRITE -> interface_write = 0 asynchronously and busy = 0.
- SDRAM_WRITER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, ack never given -> timeout_error = 1 after 16 cycles, done pulses, state IDLE.
